// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 writeback stage.
package lc3_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_COUNT = 8;
  localparam int ADDR_W    = $clog2(REG_COUNT);

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC   = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  function automatic logic [2:0] psr_of(input logic [DATA_W-1:0] data);
    if (data[DATA_W-1])   return PSR_N;
    else if (data == '0)  return PSR_Z;
    else                  return PSR_P;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8 x 16 register file: one synchronous write port, two combinational read
// ports, asynchronous active-low clear of every entry.
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: write-data select, register file and N/Z/P flags.
// Define LC3_WB_BYPASS_EN to forward the write data onto matching read ports.
module lc3_writeback
  import lc3_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] memout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [ADDR_W-1:0] dr,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr
);

  wb_sel_e           sel;
  logic [DATA_W-1:0] dr_in;
  logic              wr_en;
  logic [2:0]        psr_q, psr_d;
  logic [DATA_W-1:0] rd1, rd2;

  assign sel = wb_sel_e'(W_Control);

  always_comb begin
    dr_in = '0;
    case (sel)
      WB_ALU:  dr_in = aluout;
      WB_MEM:  dr_in = memout;
      WB_PC:   dr_in = pcout;
      default: dr_in = '0;
    endcase
  end

  // The reserved select blocks both the register write and the flag update.
  assign wr_en = enable_writeback && (sel != WB_RSVD);

  always_comb begin
    psr_d = psr_q;
    if (wr_en) psr_d = psr_of(dr_in);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) psr_q <= 3'b000;
    else        psr_q <= psr_d;
  end

  lc3_regfile u_regfile (
    .clk_i    (clock),
    .rst_ni   (reset),
    .we_i     (wr_en),
    .waddr_i  (dr),
    .wdata_i  (dr_in),
    .raddr1_i (sr1),
    .raddr2_i (sr2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

`ifdef LC3_WB_BYPASS_EN
  // Forwarding is gated by reset so the ports read zero while cleared.
  logic fwd1, fwd2;
  assign fwd1 = reset && wr_en && (sr1 == dr);
  assign fwd2 = reset && wr_en && (sr2 == dr);
  assign VSR1 = fwd1 ? dr_in : rd1;
  assign VSR2 = fwd2 ? dr_in : rd2;
`else
  assign VSR1 = rd1;
  assign VSR2 = rd2;
`endif

  assign psr = psr_q;

`ifndef SYNTHESIS
  a_wctl_known: assert property (@(posedge clock) disable iff (!reset)
    enable_writeback |-> !$isunknown(W_Control));
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: table-driven vectors through a
// scoreboard queue plus hand-written same-cycle-read and mid-write reset cases.
module tb_lc3_writeback;

  logic        clock;
  logic        reset;
  logic        enable_writeback;
  logic [1:0]  W_Control;
  logic [15:0] aluout, memout, pcout;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] VSR1, VSR2;
  logic [2:0]  psr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic [1:0]  ctl;
    logic [15:0] alu, mem, pc;
    logic [2:0]  dr, sr1, sr2;
    logic [15:0] e1, e2;
    logic [2:0]  ep;
  } vec_t;

  typedef struct {
    logic [15:0] v1, v2;
    logic [2:0]  p;
  } exp_t;

  vec_t vecs [10];
  exp_t sb_q [$];

  lc3_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .W_Control        (W_Control),
    .aluout           (aluout),
    .memout           (memout),
    .pcout            (pcout),
    .dr               (dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .psr              (psr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] ctl, input logic [15:0] a,
                       input logic [15:0] m, input logic [15:0] p, input logic [2:0] d,
                       input logic [2:0] s1, input logic [2:0] s2);
    enable_writeback = en;
    W_Control        = ctl;
    aluout           = a;
    memout           = m;
    pcout            = p;
    dr               = d;
    sr1              = s1;
    sr2              = s2;
  endtask

  task automatic push(input logic [15:0] v1, input logic [15:0] v2, input logic [2:0] p);
    exp_t e;
    e.v1 = v1;
    e.v2 = v2;
    e.p  = p;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s_sb actual=empty required=entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_vsr1"}, VSR1, e.v1);
      check({name, "_vsr2"}, VSR2, e.v2);
      check({name, "_psr"}, {13'd0, psr}, {13'd0, e.p});
      $display("txn %s sr1=%0d sr2=%0d VSR1=%h VSR2=%h psr=%b", name, sr1, sr2, VSR1, VSR2, psr);
    end
  endtask

  initial begin
    logic [15:0] exp_same;

    vecs[0] = '{1'b1, 2'd0, 16'h8001, 16'h1111, 16'h2222, 3'd3, 3'd3, 3'd0, 16'h8001, 16'h0000, 3'b100};
    vecs[1] = '{1'b1, 2'd1, 16'h5555, 16'h0000, 16'h6666, 3'd5, 3'd5, 3'd3, 16'h0000, 16'h8001, 3'b010};
    vecs[2] = '{1'b1, 2'd2, 16'h9999, 16'hAAAA, 16'h3005, 3'd6, 3'd6, 3'd5, 16'h3005, 16'h0000, 3'b001};
    vecs[3] = '{1'b1, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd2, 3'd2, 3'd6, 16'h0000, 16'h3005, 3'b001};
    vecs[4] = '{1'b0, 2'd0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'd1, 3'd1, 3'd3, 16'h0000, 16'h8001, 3'b001};
    vecs[5] = '{1'b1, 2'd0, 16'hFFFF, 16'h0001, 16'h0002, 3'd7, 3'd7, 3'd7, 16'hFFFF, 16'hFFFF, 3'b100};
    vecs[6] = '{1'b1, 2'd1, 16'h8000, 16'h7FFF, 16'h0000, 3'd0, 3'd0, 3'd7, 16'h7FFF, 16'hFFFF, 3'b001};
    vecs[7] = '{1'b1, 2'd2, 16'h0000, 16'h0001, 16'h8000, 3'd3, 3'd3, 3'd6, 16'h8000, 16'h3005, 3'b100};
    vecs[8] = '{1'b1, 2'd0, 16'h0000, 16'hF00F, 16'h1234, 3'd7, 3'd7, 3'd0, 16'h0000, 16'h7FFF, 3'b010};
    vecs[9] = '{1'b1, 2'd1, 16'h8888, 16'h0001, 16'h0000, 3'd1, 3'd1, 3'd2, 16'h0001, 16'h0000, 3'b001};

    // Reset: every read-port combination must return zero.
    reset = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        sr1 = 3'(i);
        sr2 = 3'(j);
        #1;
        check($sformatf("rst_r%0d_r%0d_vsr1", i, j), VSR1, 16'h0000);
        check($sformatf("rst_r%0d_r%0d_vsr2", i, j), VSR2, 16'h0000);
      end
    end
    check("rst_psr", {13'd0, psr}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      drive(vecs[k].en, vecs[k].ctl, vecs[k].alu, vecs[k].mem, vecs[k].pc,
            vecs[k].dr, vecs[k].sr1, vecs[k].sr2);
      push(vecs[k].e1, vecs[k].e2, vecs[k].ep);
      @(posedge clock);
      #1;
      pop_check($sformatf("vec%0d", k));
    end

    // Same-cycle read of the register being written.
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h4444, 16'h0, 16'h0, 3'd4, 3'd0, 3'd0);
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h1234, 16'hDEAD, 16'hBEEF, 3'd4, 3'd4, 3'd4);
    #1;
`ifdef LC3_WB_BYPASS_EN
    exp_same = 16'h1234;
`else
    exp_same = 16'h4444;
`endif
    check("same_cycle_vsr1", VSR1, exp_same);
    check("same_cycle_vsr2", VSR2, exp_same);
    push(16'h1234, 16'h1234, 3'b001);
    @(posedge clock);
    #1;
    pop_check("same_next");

    // Reset asserted in the middle of a write cycle wins over the write.
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h7777, 16'h0, 16'h0, 3'd1, 3'd1, 3'd4);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_now_vsr1", VSR1, 16'h0000);
    check("midrst_now_vsr2", VSR2, 16'h0000);
    check("midrst_now_psr", {13'd0, psr}, 16'h0000);
    push(16'h0000, 16'h0000, 3'b000);
    @(posedge clock);
    #1;
    pop_check("midrst_edge");
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 2'd0, 16'h7777, 16'h0, 16'h0, 3'd1, 3'd1, 3'd4);
    push(16'h0000, 16'h0000, 3'b000);
    @(posedge clock);
    #1;
    pop_check("midrst_release");
    for (int r = 0; r < 8; r++) begin
      sr1 = 3'(r);
      #1;
      check($sformatf("midrst_r%0d", r), VSR1, 16'h0000);
    end

    // First write after release is not lost.
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h7777, 16'h0, 16'h0, 3'd1, 3'd1, 3'd4);
    push(16'h7777, 16'h0000, 3'b001);
    @(posedge clock);
    #1;
    pop_check("post_rst_write");

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
